// File: rtl/apb_gpio_v2.sv
// apb_gpio_v2: APB3 GPIO with atomic set/clear/toggle, per-pin debounce,
// level/edge/both-edge interrupts and programmable APB wait states.

// Per-pin input path: two-flop synchroniser, debounce filter, delayed copy
// for edge detection, and the interrupt set condition for this pin.
module apb_gpio_v2_pin #(
    parameter int DEB_W = 8
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             pin,
    input  logic             deb_en,
    input  logic [DEB_W-1:0] deb_cnt,
    input  logic             int_en,
    input  logic             int_type,
    input  logic             int_pol,
    input  logic             int_both,
    output logic             filt,
    output logic             set_evt
);
    logic             s1_q, s1_d, s2_q, s2_d;
    logic             filt_q, filt_d, filt_dly_q, filt_dly_d;
    logic [DEB_W-1:0] dcnt_q, dcnt_d;

    // Synchroniser shift, debounce counter and filtered value
    always_comb begin
        s1_d       = pin;
        s2_d       = s1_q;
        filt_d     = filt_q;
        dcnt_d     = dcnt_q;
        filt_dly_d = filt_q;
        if (!deb_en) begin
            filt_d = s2_q;
            dcnt_d = '0;
        end else if (s2_q == filt_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == deb_cnt) begin
            // threshold compare is live, so a lowered DEB_CNT below dcnt
            // only matches after the counter wraps
            filt_d = s2_q;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    // Interrupt set condition, masked by the pin enable
    always_comb begin
        set_evt = 1'b0;
        if (int_en) begin
            if (!int_type)     set_evt = (filt_q == int_pol);
            else if (int_both) set_evt = filt_q ^ filt_dly_q;
            else if (int_pol)  set_evt = filt_q & ~filt_dly_q;
            else               set_evt = ~filt_q & filt_dly_q;
        end
    end

    // Input path state
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            dcnt_q     <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_dly_d;
            dcnt_q     <= dcnt_d;
        end
    end

    assign filt = filt_q;
endmodule

module apb_gpio_v2 #(
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_GPIOS   = 32,
    parameter int DEB_W       = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic [NUM_GPIOS-1:0]  gpio_in,
    output logic [NUM_GPIOS-1:0]  gpio_out,
    output logic [NUM_GPIOS-1:0]  gpio_oe,
    output logic                  gpio_irq
);
    localparam logic [1:0] WS = 2'(WAIT_STATES);

    localparam logic [7:0] A_DATA_OUT = 8'h00, A_DIR      = 8'h04, A_DATA_IN  = 8'h08,
                           A_SET      = 8'h0C, A_CLR      = 8'h10, A_TGL      = 8'h14,
                           A_INT_EN   = 8'h18, A_INT_STAT = 8'h1C, A_INT_TYPE = 8'h20,
                           A_INT_POL  = 8'h24, A_INT_BOTH = 8'h28, A_DEB_EN   = 8'h2C,
                           A_DEB_CNT  = 8'h30;

    logic [7:0]           offs;
    logic                 access, wr_en, mapped;
    logic [1:0]           wcnt_q, wcnt_d;
    logic [31:0]          rdata;
    logic [NUM_GPIOS-1:0] wmask;

    logic [NUM_GPIOS-1:0] data_out_q, data_out_d, dir_q, dir_d;
    logic [NUM_GPIOS-1:0] int_en_q, int_en_d, int_stat_q, int_stat_d;
    logic [NUM_GPIOS-1:0] int_type_q, int_type_d, int_pol_q, int_pol_d;
    logic [NUM_GPIOS-1:0] int_both_q, int_both_d, deb_en_q, deb_en_d;
    logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
    logic [NUM_GPIOS-1:0] filt_vec, set_vec;

    assign offs   = paddr[7:0];
    assign access = psel & penable;
    // reset gates pready so an aborted transfer can never complete
    assign pready = access & (wcnt_q == WS) & ~preset;
    assign wr_en  = pready & pwrite;
    assign wmask  = pwdata[NUM_GPIOS-1:0];

    // Wait-state counter: runs only during the access phase
    always_comb begin
        wcnt_d = '0;
        if (access) wcnt_d = (wcnt_q != WS) ? wcnt_q + 2'd1 : wcnt_q;
    end

    // Address decode and read mux
    always_comb begin
        mapped = 1'b1;
        rdata  = '0;
        case (offs)
            A_DATA_OUT: rdata = 32'(data_out_q);
            A_DIR:      rdata = 32'(dir_q);
            A_DATA_IN:  rdata = 32'(filt_vec);
            A_SET, A_CLR, A_TGL: rdata = '0;
            A_INT_EN:   rdata = 32'(int_en_q);
            A_INT_STAT: rdata = 32'(int_stat_q);
            A_INT_TYPE: rdata = 32'(int_type_q);
            A_INT_POL:  rdata = 32'(int_pol_q);
            A_INT_BOTH: rdata = 32'(int_both_q);
            A_DEB_EN:   rdata = 32'(deb_en_q);
            A_DEB_CNT:  rdata = 32'(deb_cnt_q);
            default:    mapped = 1'b0;
        endcase
    end

    assign prdata  = pready ? rdata : '0;
    assign pslverr = pready & ~mapped;

    // Register write side; interrupt set events always win over W1C
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        int_en_d   = int_en_q;
        int_stat_d = int_stat_q | set_vec;
        int_type_d = int_type_q;
        int_pol_d  = int_pol_q;
        int_both_d = int_both_q;
        deb_en_d   = deb_en_q;
        deb_cnt_d  = deb_cnt_q;
        if (wr_en) begin
            case (offs)
                A_DATA_OUT: data_out_d = wmask;
                A_DIR:      dir_d      = wmask;
                A_SET:      data_out_d = data_out_q | wmask;
                A_CLR:      data_out_d = data_out_q & ~wmask;
                A_TGL:      data_out_d = data_out_q ^ wmask;
                A_INT_EN:   int_en_d   = wmask;
                A_INT_STAT: int_stat_d = (int_stat_q & ~wmask) | set_vec;
                A_INT_TYPE: int_type_d = wmask;
                A_INT_POL:  int_pol_d  = wmask;
                A_INT_BOTH: int_both_d = wmask;
                A_DEB_EN:   deb_en_d   = wmask;
                A_DEB_CNT:  deb_cnt_d  = pwdata[DEB_W-1:0];
                default: ;
            endcase
        end
    end

    // Register and wait-counter state
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wcnt_q     <= '0;
            data_out_q <= '0;
            dir_q      <= '0;
            int_en_q   <= '0;
            int_stat_q <= '0;
            int_type_q <= '0;
            int_pol_q  <= '0;
            int_both_q <= '0;
            deb_en_q   <= '0;
            deb_cnt_q  <= '0;
        end else begin
            wcnt_q     <= wcnt_d;
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            int_en_q   <= int_en_d;
            int_stat_q <= int_stat_d;
            int_type_q <= int_type_d;
            int_pol_q  <= int_pol_d;
            int_both_q <= int_both_d;
            deb_en_q   <= deb_en_d;
            deb_cnt_q  <= deb_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_GPIOS; g++) begin : g_pin
        apb_gpio_v2_pin #(.DEB_W(DEB_W)) u_pin (
            .pclk     (pclk),
            .preset   (preset),
            .pin      (gpio_in[g]),
            .deb_en   (deb_en_q[g]),
            .deb_cnt  (deb_cnt_q),
            .int_en   (int_en_q[g]),
            .int_type (int_type_q[g]),
            .int_pol  (int_pol_q[g]),
            .int_both (int_both_q[g]),
            .filt     (filt_vec[g]),
            .set_evt  (set_vec[g])
        );
    end

    assign gpio_out = data_out_q;
    assign gpio_oe  = dir_q;
    assign gpio_irq = |(int_stat_q & int_en_q);
endmodule

// File: tb/tb_apb_gpio_v2.sv
// Directed bench for apb_gpio_v2 (16 pins, 2 wait states): register table
// plus hand sequences for interrupts, debounce, W1C race and reset abort.
module tb_apb_gpio_v2;
    localparam int NG = 16;

    logic          pclk = 1'b0, preset = 1'b1;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]    paddr = '0;
    logic [31:0]   pwdata = '0, prdata;
    logic          pready, pslverr, gpio_irq;
    logic [NG-1:0] gpio_in = '0, gpio_out, gpio_oe;

    int n_vec = 0, n_err = 0;

    apb_gpio_v2 #(.ADDR_WIDTH(8), .NUM_GPIOS(NG), .DEB_W(8), .WAIT_STATES(2)) dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .gpio_irq(gpio_irq)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        logic [15:0] out;
        logic [15:0] oe;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                               input logic [31:0] rd, input logic err,
                               input logic [15:0] out, input logic [15:0] oe);
        vec_t t;
        t.wr = wr; t.addr = a; t.wd = wd; t.rd = rd; t.err = err; t.out = out; t.oe = oe;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // One APB transfer; also checks setup-phase pready and access length
    task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
        int   n;
        logic done;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        #1 chk("setup_pready", 32'(pready), 32'd0);
        @(posedge pclk); #1;
        penable = 1'b1;
        n = 0; done = 1'b0; rd = '0; err = 1'b0;
        while (!done && n < 8) begin
            #1;
            n++;
            if (pready) begin
                rd = prdata; err = pslverr; done = 1'b1;
            end
            @(posedge pclk); #1;
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        chk("pready_timeout", 32'(done), 32'd1);
        chk("access_cycles", 32'(n), 32'd3);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic        e;
        apb(1'b1, a, d, r, e);
    endtask

    task automatic rdc(input string nm, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        apb(1'b0, a, 32'd0, r, e);
        chk(nm, r, exp);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;

        // register table: reset reads, atomic output ops, masking, errors
        for (int a = 0; a <= 8'h30; a += 4) tbl.push_back(v(0, 8'(a), 0, 0, 0, 16'h0, 16'h0));
        tbl.push_back(v(1, 8'h00, 32'h0000_00F0, 0, 0, 16'h00F0, 16'h0));
        tbl.push_back(v(1, 8'h0C, 32'h0000_000F, 0, 0, 16'h00FF, 16'h0));
        tbl.push_back(v(1, 8'h10, 32'h0000_0030, 0, 0, 16'h00CF, 16'h0));
        tbl.push_back(v(1, 8'h14, 32'h0000_0081, 0, 0, 16'h004E, 16'h0));
        tbl.push_back(v(0, 8'h00, 0, 32'h0000_004E, 0, 16'h004E, 16'h0));
        tbl.push_back(v(1, 8'h0C, 32'hFFFF_0000, 0, 0, 16'h004E, 16'h0));
        tbl.push_back(v(0, 8'h0C, 0, 32'h0, 0, 16'h004E, 16'h0));
        tbl.push_back(v(0, 8'h10, 0, 32'h0, 0, 16'h004E, 16'h0));
        tbl.push_back(v(0, 8'h14, 0, 32'h0, 0, 16'h004E, 16'h0));
        tbl.push_back(v(1, 8'h04, 32'hFFFF_A5A5, 0, 0, 16'h004E, 16'hA5A5));
        tbl.push_back(v(0, 8'h04, 0, 32'h0000_A5A5, 0, 16'h004E, 16'hA5A5));
        tbl.push_back(v(1, 8'h30, 32'h0000_FFFF, 0, 0, 16'h004E, 16'hA5A5));
        tbl.push_back(v(0, 8'h30, 0, 32'h0000_00FF, 0, 16'h004E, 16'hA5A5));
        tbl.push_back(v(1, 8'h30, 32'h0, 0, 0, 16'h004E, 16'hA5A5));
        tbl.push_back(v(1, 8'h2C, 32'hFFFF_FFFF, 0, 0, 16'h004E, 16'hA5A5));
        tbl.push_back(v(0, 8'h2C, 0, 32'h0000_FFFF, 0, 16'h004E, 16'hA5A5));
        tbl.push_back(v(1, 8'h2C, 32'h0, 0, 0, 16'h004E, 16'hA5A5));
        tbl.push_back(v(1, 8'h40, 32'h1234_5678, 0, 1, 16'h004E, 16'hA5A5));
        tbl.push_back(v(0, 8'h40, 0, 32'h0, 1, 16'h004E, 16'hA5A5));
        tbl.push_back(v(1, 8'h02, 32'hFFFF_FFFF, 0, 1, 16'h004E, 16'hA5A5));
        tbl.push_back(v(0, 8'h34, 0, 32'h0, 1, 16'h004E, 16'hA5A5));
        tbl.push_back(v(0, 8'h00, 0, 32'h0000_004E, 0, 16'h004E, 16'hA5A5));
        tbl.push_back(v(1, 8'h04, 32'h0, 0, 0, 16'h004E, 16'h0));

        // reset with a transfer pending: nothing may complete
        psel = 1'b1; penable = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_out", 32'(gpio_out), 32'd0);
        chk("rst_oe", 32'(gpio_oe), 32'd0);
        chk("rst_irq", 32'(gpio_irq), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk) preset = 1'b0;

        foreach (tbl[i]) begin
            apb(tbl[i].wr, tbl[i].addr, tbl[i].wd, r, e);
            if (!tbl[i].wr) chk($sformatf("tbl%0d_rd", i), r, tbl[i].rd);
            chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].err));
            chk($sformatf("tbl%0d_out", i), 32'(gpio_out), 32'(tbl[i].out));
            chk($sformatf("tbl%0d_oe", i), 32'(gpio_oe), 32'(tbl[i].oe));
        end

        // unfiltered input reaches DATA_IN
        gpio_in = 16'h5A3C;
        repeat (4) @(posedge pclk);
        rdc("data_in", 8'h08, 32'h0000_5A3C);
        gpio_in = '0;
        repeat (4) @(posedge pclk);

        // both-edge interrupt on pin 3: set 4 edges after each transition
        wr(8'h20, 32'h8); wr(8'h28, 32'h8); wr(8'h18, 32'h8);
        @(posedge pclk); #1;
        gpio_in[3] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge pclk); #1;
            chk($sformatf("rise_irq_e%0d", k), 32'(gpio_irq), 32'(k == 4));
        end
        rdc("rise_stat", 8'h1C, 32'h8);
        wr(8'h1C, 32'h8);
        rdc("rise_w1c", 8'h1C, 32'h0);
        chk("rise_w1c_irq", 32'(gpio_irq), 32'd0);
        gpio_in[3] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge pclk); #1;
            chk($sformatf("fall_irq_e%0d", k), 32'(gpio_irq), 32'(k == 4));
        end
        rdc("fall_stat", 8'h1C, 32'h8);
        wr(8'h1C, 32'h8);

        // debounce on pin 0, threshold 5, rising-edge interrupt
        wr(8'h18, 32'h0); wr(8'h20, 32'h1); wr(8'h24, 32'h1); wr(8'h28, 32'h0);
        wr(8'h2C, 32'h1); wr(8'h30, 32'd5); wr(8'h1C, 32'hFFFF); wr(8'h18, 32'h1);
        @(posedge pclk); #1;
        gpio_in[0] = 1'b1;
        repeat (5) @(posedge pclk);
        #1 gpio_in[0] = 1'b0;
        repeat (12) @(posedge pclk);
        #1 chk("deb5_irq", 32'(gpio_irq), 32'd0);
        rdc("deb5_data_in", 8'h08, 32'h0);
        rdc("deb5_stat", 8'h1C, 32'h0);
        @(posedge pclk); #1;
        gpio_in[0] = 1'b1;
        repeat (6) @(posedge pclk);
        #1 gpio_in[0] = 1'b0;
        repeat (12) @(posedge pclk);
        #1 chk("deb6_irq", 32'(gpio_irq), 32'd1);
        rdc("deb6_stat", 8'h1C, 32'h1);
        wr(8'h1C, 32'h1);
        rdc("deb6_w1c", 8'h1C, 32'h0);
        @(posedge pclk); #1;
        gpio_in[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge pclk); #1;
            if (k == 8)  chk("deb_hold_irq_early", 32'(gpio_irq), 32'd0);
            if (k == 10) chk("deb_hold_irq", 32'(gpio_irq), 32'd1);
        end
        rdc("deb_hold_data_in", 8'h08, 32'h1);

        // level-high on pin 7 versus W1C: set wins while the level holds
        wr(8'h18, 32'h0); wr(8'h1C, 32'hFFFF); wr(8'h20, 32'h0); wr(8'h24, 32'h80);
        gpio_in[7] = 1'b1;
        repeat (4) @(posedge pclk);
        wr(8'h18, 32'h80);
        for (int k = 0; k < 3; k++) begin
            wr(8'h1C, 32'h80);
            chk($sformatf("race_irq%0d", k), 32'(gpio_irq), 32'd1);
            rdc($sformatf("race_stat%0d", k), 8'h1C, 32'h80);
        end
        wr(8'h18, 32'h0);
        chk("mask_irq", 32'(gpio_irq), 32'd0);
        rdc("mask_stat_kept", 8'h1C, 32'h80);
        gpio_in[7] = 1'b0;
        repeat (4) @(posedge pclk);
        wr(8'h1C, 32'h80);
        rdc("race_cleared", 8'h1C, 32'h0);

        // reset during the access phase of a DATA_OUT write
        wr(8'h04, 32'hFF); wr(8'h18, 32'h80);
        gpio_in[7] = 1'b1;
        repeat (5) @(posedge pclk);
        #1 chk("pre_abort_irq", 32'(gpio_irq), 32'd1);
        @(posedge pclk); #1;
        psel = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h0000_FFFF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        #1;
        chk("abort_pready", 32'(pready), 32'd0);
        chk("abort_out", 32'(gpio_out), 32'd0);
        chk("abort_oe", 32'(gpio_oe), 32'd0);
        chk("abort_irq", 32'(gpio_irq), 32'd0);
        chk("abort_prdata", prdata, 32'd0);
        chk("abort_pslverr", 32'(pslverr), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge pclk); #1;
            chk($sformatf("abort_pready_hold%0d", k), 32'(pready), 32'd0);
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; gpio_in = '0;
        @(negedge pclk) preset = 1'b0;
        rdc("abort_data_out", 8'h00, 32'h0);
        rdc("abort_dir", 8'h04, 32'h0);
        rdc("abort_int_en", 8'h18, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
